// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the two-port memory arbiter.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package mem_arb_pkg;

    localparam int AWIDTH_DEF = 32;
    localparam int DWIDTH_DEF = 32;
    localparam int CNTW_DEF   = 16;

    // Which port is waiting for read data from the access issued last cycle.
    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_DATA  = 2'd2
    } owner_e;

    // Port that received the most recent grant; used to break ties.
    typedef enum logic {
        LAST_FETCH = 1'b0,
        LAST_DATA  = 1'b1
    } last_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: counts inc pulses and sticks at all-ones.
// Latency: count visible the cycle after the inc pulse.
// Backpressure: none; inc pulses arriving once saturated are dropped.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    // Count up on each pulse, hold at the maximum value instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter onto a single-ported synchronous memory.
// Latency: grant and memory strobes combinational; read data returns 1 cycle later.
// Backpressure: a losing requester is simply not granted and must hold its request.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AWIDTH = AWIDTH_DEF,
    parameter int DWIDTH = DWIDTH_DEF,
    parameter int CNTW   = CNTW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    // fetch port (read only)
    input  logic              f_req_i,
    input  logic [AWIDTH-1:0] f_addr_i,
    output logic              f_gnt_o,
    output logic              f_rvalid_o,
    output logic [DWIDTH-1:0] f_rdata_o,
    // data port (read / write)
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [AWIDTH-1:0] d_addr_i,
    input  logic [DWIDTH-1:0] d_wdata_i,
    output logic              d_gnt_o,
    output logic              d_rvalid_o,
    output logic [DWIDTH-1:0] d_rdata_o,
    // memory side
    output logic [AWIDTH-1:0] mem_addr_o,
    output logic [DWIDTH-1:0] mem_data_o,
    output logic              mem_read_en_o,
    output logic              mem_write_en_o,
    input  logic [DWIDTH-1:0] mem_data_i,
    // grant statistics
    output logic [CNTW-1:0]   f_gnt_cnt_o,
    output logic [CNTW-1:0]   d_gnt_cnt_o
);

    last_e  last_q, last_d;
    owner_e own_q, own_d;
    logic   f_win, d_win;

    // Pick a winner: a lone requester wins outright, a tie goes to the port
    // that did not win last time. Nothing is granted while in reset.
    always_comb begin
        f_win = 1'b0;
        d_win = 1'b0;
        if (!rst) begin
            if (f_req_i && d_req_i) begin
                f_win = (last_q == LAST_DATA);
                d_win = (last_q == LAST_FETCH);
            end else begin
                f_win = f_req_i;
                d_win = d_req_i;
            end
        end
    end

    assign f_gnt_o = f_win;
    assign d_gnt_o = d_win;

    // Steer the winner onto the memory bus; idle bus is driven to all zeros.
    always_comb begin
        mem_addr_o     = '0;
        mem_data_o     = '0;
        mem_read_en_o  = 1'b0;
        mem_write_en_o = 1'b0;
        if (f_win) begin
            mem_addr_o    = f_addr_i;
            mem_read_en_o = 1'b1;
        end else if (d_win) begin
            mem_addr_o = d_addr_i;
            if (d_we_i) begin
                mem_write_en_o = 1'b1;
                mem_data_o     = d_wdata_i;
            end else begin
                mem_read_en_o = 1'b1;
            end
        end
    end

    // Next tie-break and owner tag: tie-break moves only on a grant, the
    // owner tag only marks reads (writes return nothing).
    always_comb begin
        last_d = last_q;
        own_d  = OWN_NONE;
        if (f_win) begin
            last_d = LAST_FETCH;
            own_d  = OWN_FETCH;
        end else if (d_win) begin
            last_d = LAST_DATA;
            own_d  = d_we_i ? OWN_NONE : OWN_DATA;
        end
    end

    // State registers; reset leaves DATA as last winner so fetch takes the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= LAST_DATA;
            own_q  <= OWN_NONE;
        end else begin
            last_q <= last_d;
            own_q  <= own_d;
        end
    end

    // rvalid is also masked by rst so a read issued just before reset never
    // reports data in the reset cycle.
    assign f_rvalid_o = !rst && (own_q == OWN_FETCH);
    assign d_rvalid_o = !rst && (own_q == OWN_DATA);
    assign f_rdata_o  = mem_data_i;
    assign d_rdata_o  = mem_data_i;

    sat_counter #(.W(CNTW)) u_f_cnt (
        .clk (clk),
        .rst (rst),
        .inc (f_win),
        .cnt (f_gnt_cnt_o)
    );

    sat_counter #(.W(CNTW)) u_d_cnt (
        .clk (clk),
        .rst (rst),
        .inc (d_win),
        .cnt (d_gnt_cnt_o)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vectors plus a per-cycle model.
// Latency: n/a.
// Backpressure: n/a.
module tb_mem_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          f_req, d_req, d_we;
    logic [AW-1:0] f_addr, d_addr;
    logic [DW-1:0] d_wdata;
    logic          f_gnt, f_rvalid, d_gnt, d_rvalid;
    logic [DW-1:0] f_rdata, d_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdat;
    logic          mem_rd, mem_wr;
    logic [DW-1:0] mem_rdat;
    logic [CW-1:0] f_cnt, d_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .CNTW(CW)) dut (
        .clk            (clk),
        .rst            (rst),
        .f_req_i        (f_req),
        .f_addr_i       (f_addr),
        .f_gnt_o        (f_gnt),
        .f_rvalid_o     (f_rvalid),
        .f_rdata_o      (f_rdata),
        .d_req_i        (d_req),
        .d_we_i         (d_we),
        .d_addr_i       (d_addr),
        .d_wdata_i      (d_wdata),
        .d_gnt_o        (d_gnt),
        .d_rvalid_o     (d_rvalid),
        .d_rdata_o      (d_rdata),
        .mem_addr_o     (mem_addr),
        .mem_data_o     (mem_wdat),
        .mem_read_en_o  (mem_rd),
        .mem_write_en_o (mem_wr),
        .mem_data_i     (mem_rdat),
        .f_gnt_cnt_o    (f_cnt),
        .d_gnt_cnt_o    (d_cnt)
    );

    function automatic logic [31:0] dflt(input int i);
        return 32'h5A5A_0000 + 32'(i);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Memory environment: 256 words indexed by addr[9:2], one-cycle read.
    logic [31:0] bmem [256];
    initial begin
        logic       rd, wr;
        logic [7:0] ix;
        logic [31:0] wd;
        for (int i = 0; i < 256; i++) bmem[i] = dflt(i);
        mem_rdat = 32'hBAD0_0000;
        forever begin
            @(negedge clk);
            rd = mem_rd;
            wr = mem_wr;
            ix = mem_addr[9:2];
            wd = mem_wdat;
            @(posedge clk);
            mem_rdat <= rd ? bmem[ix] : 32'hBAD0_0000;
            if (wr) bmem[ix] = wd;
        end
    end

    // Behavioural model: who should win, what the bus shows, which read is
    // outstanding and what it must return, plus saturating grant tallies.
    logic [31:0] m_mem [256];
    initial begin
        bit          m_last_data;
        int          m_pend;
        logic [31:0] m_pdat;
        int          m_fc, m_dc;
        logic        ef, ed;
        m_last_data = 1'b1;
        m_pend      = 0;
        m_pdat      = '0;
        m_fc        = 0;
        m_dc        = 0;
        for (int i = 0; i < 256; i++) m_mem[i] = dflt(i);
        @(posedge clk);
        forever begin
            @(negedge clk);
            ef = 1'b0;
            ed = 1'b0;
            if (!rst) begin
                if (f_req && d_req) begin
                    if (m_last_data) ef = 1'b1; else ed = 1'b1;
                end else begin
                    ef = f_req;
                    ed = d_req;
                end
            end
            chk("m_f_gnt", 32'(f_gnt), 32'(ef));
            chk("m_d_gnt", 32'(d_gnt), 32'(ed));
            chk("m_rd_en", 32'(mem_rd), 32'(ef || (ed && !d_we)));
            chk("m_wr_en", 32'(mem_wr), 32'(ed && d_we));
            chk("m_addr", mem_addr, ef ? f_addr : (ed ? d_addr : 32'h0));
            if (!ef && !(ed && !d_we))
                chk("m_wdata", mem_wdat, (ed && d_we) ? d_wdata : 32'h0);
            chk("m_f_rvalid", 32'(f_rvalid), 32'(!rst && m_pend == 1));
            chk("m_d_rvalid", 32'(d_rvalid), 32'(!rst && m_pend == 2));
            if (!rst && m_pend == 1) chk("m_f_rdata", f_rdata, m_pdat);
            if (!rst && m_pend == 2) chk("m_d_rdata", d_rdata, m_pdat);
            chk("m_f_cnt", 32'(f_cnt), 32'(m_fc));
            chk("m_d_cnt", 32'(d_cnt), 32'(m_dc));
            if (rst) begin
                m_last_data = 1'b1;
                m_pend      = 0;
                m_fc        = 0;
                m_dc        = 0;
            end else if (ef) begin
                m_last_data = 1'b0;
                m_pend      = 1;
                m_pdat      = m_mem[f_addr[9:2]];
                m_fc        = (m_fc < CMAX) ? m_fc + 1 : CMAX;
            end else if (ed) begin
                m_last_data = 1'b1;
                if (d_we) begin
                    m_mem[d_addr[9:2]] = d_wdata;
                    m_pend = 0;
                end else begin
                    m_pend = 2;
                    m_pdat = m_mem[d_addr[9:2]];
                end
                m_dc = (m_dc < CMAX) ? m_dc + 1 : CMAX;
            end else begin
                m_pend = 0;
            end
        end
    end

    // Drive one cycle of inputs just after the edge, return at the mid-cycle
    // point so the caller can check that cycle's outputs.
    task automatic step(input logic r, input logic fr, input logic [31:0] fa,
                        input logic dr, input logic dw, input logic [31:0] da,
                        input logic [31:0] dd);
        @(posedge clk);
        #1;
        rst = r; f_req = fr; f_addr = fa;
        d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
        @(negedge clk);
    endtask

    initial begin
        logic [5:0] exp_f;
        exp_f = 6'b010101;
        rst = 1'b1; f_req = 1'b0; f_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;

        // reset state, and no grant while in reset
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        chk("rst_f_gnt", 32'(f_gnt), 32'd0);
        chk("rst_f_cnt", 32'(f_cnt), 32'd0);
        chk("rst_d_cnt", 32'(d_cnt), 32'd0);
        step(1, 1, 32'h10, 0, 0, 0, 0);
        chk("rst_req_no_gnt", 32'(f_gnt), 32'd0);
        chk("rst_req_no_rd", 32'(mem_rd), 32'd0);

        // both ports reading continuously: F,D,F,D,F,D
        for (int i = 0; i < 6; i++) begin
            step(0, 1, 32'h40, 1, 0, 32'h80, 0);
            chk("alt_f_gnt", 32'(f_gnt), 32'(exp_f[i]));
            chk("alt_d_gnt", 32'(d_gnt), 32'(!exp_f[i]));
        end
        step(0, 0, 0, 0, 0, 0, 0);
        chk("alt_f_cnt", 32'(f_cnt), 32'd3);
        chk("alt_d_cnt", 32'(d_cnt), 32'd3);
        chk("alt_d_rvalid", 32'(d_rvalid), 32'd1);
        chk("alt_d_rdata", d_rdata, 32'h5A5A_0020);

        // idle cycles between ties leave the tie-break alone
        step(0, 1, 32'h44, 1, 0, 32'h84, 0);
        chk("tie1_f_gnt", 32'(f_gnt), 32'd1);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 32'h44, 1, 0, 32'h84, 0);
        chk("tie2_d_gnt", 32'(d_gnt), 32'd1);
        chk("tie2_f_gnt", 32'(f_gnt), 32'd0);
        step(0, 0, 0, 0, 0, 0, 0);

        // fetch-only read of 0x10
        step(0, 1, 32'h10, 0, 0, 0, 0);
        chk("fr_gnt", 32'(f_gnt), 32'd1);
        chk("fr_addr", mem_addr, 32'h10);
        chk("fr_rd_en", 32'(mem_rd), 32'd1);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("fr_rvalid", 32'(f_rvalid), 32'd1);
        chk("fr_rdata", f_rdata, 32'h5A5A_0004);
        chk("fr_d_rvalid", 32'(d_rvalid), 32'd0);

        // data write then read back
        step(0, 0, 0, 1, 1, 32'h100, 32'hDEAD_BEEF);
        chk("dw_gnt", 32'(d_gnt), 32'd1);
        chk("dw_wr_en", 32'(mem_wr), 32'd1);
        chk("dw_rd_en", 32'(mem_rd), 32'd0);
        chk("dw_wdata", mem_wdat, 32'hDEAD_BEEF);
        step(0, 0, 0, 1, 0, 32'h100, 0);
        chk("dr_rd_en", 32'(mem_rd), 32'd1);
        chk("dr_wr_en", 32'(mem_wr), 32'd0);
        chk("dw_no_rvalid", 32'(d_rvalid), 32'd0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("dr_rvalid", 32'(d_rvalid), 32'd1);
        chk("dr_rdata", d_rdata, 32'hDEAD_BEEF);
        chk("dr_f_rvalid", 32'(f_rvalid), 32'd0);

        // read granted, then reset the next cycle
        step(0, 1, 32'h20, 0, 0, 0, 0);
        chk("rr_gnt", 32'(f_gnt), 32'd1);
        step(1, 1, 32'h20, 0, 0, 0, 0);
        chk("rr_no_rvalid", 32'(f_rvalid), 32'd0);
        chk("rr_no_gnt", 32'(f_gnt), 32'd0);
        step(1, 0, 0, 0, 0, 0, 0);
        chk("rr_f_cnt", 32'(f_cnt), 32'd0);
        chk("rr_d_cnt", 32'(d_cnt), 32'd0);
        chk("rr_rvalid", 32'(f_rvalid), 32'd0);
        step(0, 1, 32'h48, 1, 0, 32'h88, 0);
        chk("rr_first_tie", 32'(f_gnt), 32'd1);

        // counter saturation: 1 + 20 fetch grants
        for (int k = 0; k < 20; k++)
            step(0, 1, 32'h200 + 32'(4 * k), 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("sat_f_cnt", 32'(f_cnt), 32'd15);
        chk("sat_d_cnt", 32'(d_cnt), 32'd0);
        step(0, 0, 0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter AWIDTH, default 32, address width in bits.
REQ-002 SHALL have parameter DWIDTH, default 32, data width in bits.
REQ-003 SHALL have parameter CNTW, default 16, width of the grant-statistics counters.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 f_req_i  in  1  fetch read request.
REQ-007 f_addr_i  in  AWIDTH  fetch address.
REQ-008 f_gnt_o  out  1  fetch request accepted this cycle.
REQ-009 f_rvalid_o  out  1  fetch read data valid.
REQ-010 f_rdata_o  out  DWIDTH  fetch read data.
REQ-011 d_req_i  in  1  data-port request.
REQ-012 d_we_i  in  1  data-port write (1) or read (0).
REQ-013 d_addr_i  in  AWIDTH  data-port address.
REQ-014 d_wdata_i  in  DWIDTH  data-port write data.
REQ-015 d_gnt_o  out  1  data request accepted this cycle.
REQ-016 d_rvalid_o  out  1  data read data valid.
REQ-017 d_rdata_o  out  DWIDTH  data read data.
REQ-018 mem_addr_o  out  AWIDTH  memory address.
REQ-019 mem_data_o  out  DWIDTH  memory write data.
REQ-020 mem_read_en_o  out  1  memory read strobe.
REQ-021 mem_write_en_o  out  1  memory write strobe.
REQ-022 mem_data_i  in  DWIDTH  memory read data, valid one cycle after mem_read_en_o.
REQ-023 f_gnt_cnt_o, d_gnt_cnt_o  out  CNTW  saturating grant counters.

Function
REQ-024 SHALL arbitrate every cycle and grant at most one requester; the grant, the memory strobe, the address and the write data are combinational in that cycle.
REQ-025 With a single requester active, SHALL grant it immediately.
REQ-026 With both active, SHALL grant the requester not granted last, using a 1-bit last-grant register; after reset, the fetch port SHALL win the first tie.
REQ-027 The last-grant register SHALL update only on a grant, not in idle cycles.
REQ-028 A fetch grant SHALL assert mem_read_en_o; a data grant SHALL assert mem_write_en_o if d_we_i=1, else mem_read_en_o; both strobes SHALL never be high together.
REQ-029 With no grant, mem_read_en_o and mem_write_en_o SHALL be 0, and mem_addr_o and mem_data_o SHALL be 0.
REQ-030 Read latency SHALL be exactly 1 cycle: a registered owner tag (NONE/FETCH/DATA) SHALL route mem_data_i to the owner and pulse its rvalid for one cycle.
REQ-031 Writes SHALL produce no rvalid.
REQ-032 f_rdata_o and d_rdata_o SHALL both be driven by mem_data_i; they are qualified only by their rvalid.
REQ-033 Back-to-back grants SHALL be allowed, giving a throughput of one access per cycle. A response and a new grant in the same cycle SHALL both be honoured.
REQ-034 Each grant counter SHALL increment by 1 on its port's grant and saturate at 2^CNTW-1 without wrapping.

Reset
REQ-035 While rst=1: all gnt and rvalid outputs 0, memory strobes 0, owner tag NONE, last-grant = DATA (so fetch wins the first tie), counters 0.
REQ-036 A read granted in the cycle rst rises SHALL NOT produce an rvalid.
REQ-037 No grant SHALL be issued while rst=1.

Structure
REQ-038 A shared package mem_arb_pkg SHALL hold the owner enum (OWN_NONE, OWN_FETCH, OWN_DATA) and the default width constants.
REQ-039 The saturating counter SHALL be one sub-module, sat_counter, instantiated twice.

Verification
REQ-040 Fetch-only read at 0x0000_0010 -> f_gnt_o=1 in cycle N; f_rvalid_o=1 in N+1 with f_rdata_o = memory word; d_rvalid_o=0.
REQ-041 Both ports request reads continuously for 6 cycles after reset -> grants alternate F,D,F,D,F,D; f_gnt_cnt_o=3, d_gnt_cnt_o=3.
REQ-042 Data write 0xDEADBEEF to 0x100 followed next cycle by a data read of 0x100 -> mem_write_en_o then mem_read_en_o; d_rvalid_o with 0xDEADBEEF; no rvalid for the write.
REQ-043 Fetch read granted and rst asserted the next cycle -> f_rvalid_o=0; all outputs and counters return to reset values.
REQ-044 With CNTW=4, 20 consecutive fetch grants -> f_gnt_cnt_o holds 15 and does not wrap.
REQ-045 Idle cycle between two tied requests -> the last-grant register is unchanged, and the port not granted last wins.
